bf_mac_feeder: RTL and testbench

- Initiator/sequencer that drives the bf16 MAC operand interface: in_1/in_2, mac_en and a clear.
- Accepts a vector length and a start command, then streams operand pairs from an upstream valid/ready source into the MAC.
- Waits for the accumulator to settle, captures it and returns it over a valid/ready result port.
- Sits between the operand buffer/DMA and the MAC datapath.

---
 rtl/bf_mac_pkg.sv | 18 +
 rtl/bf_mac_feeder.sv | 121 ++++++++++++
 tb/tb_bf_mac_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_mac_pkg.sv
// Shared types and constants for the bf16 MAC operand feeder.
package bf_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DATA_W_DEF    = 16;
  localparam int SETTLE_CYCLES = 2;

  localparam logic [15:0] BF16_ONE = 16'h3F80;
  localparam logic [15:0] BF16_TWO = 16'h4000;

endpackage

// File: rtl/bf_mac_feeder.sv
// Sequencer that clears the bf16 MAC, streams operand pairs into it, waits for the
// accumulator to settle and hands the captured result to a valid/ready consumer.
module bf_mac_feeder
  import bf_mac_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              op_valid,
  output logic              op_ready,
  output logic [DATA_W-1:0] mac_in_1,
  output logic [DATA_W-1:0] mac_in_2,
  output logic              mac_en,
  output logic              mac_clr,
  input  logic [DATA_W-1:0] mac_acc,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [2:0]        dbg_state
);

  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high. op_ready is combinational on state only; result_valid holds until taken.
  state_t             state_q;
  logic [LEN_W-1:0]   rem_q;
  logic [1:0]         settle_q;
  logic [DATA_W-1:0]  in1_q;
  logic [DATA_W-1:0]  in2_q;
  logic [DATA_W-1:0]  result_q;
  logic               en_q;
  logic               clr_q;
  logic               rv_q;
  logic               op_hs;

  assign op_ready     = (state_q == ST_STREAM);
  assign op_hs        = op_ready & op_valid;
  assign busy         = (state_q != ST_IDLE);
  assign mac_in_1     = in1_q;
  assign mac_in_2     = in2_q;
  assign mac_en       = en_q;
  assign mac_clr      = clr_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      settle_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      en_q     <= 1'b0;
      clr_q    <= 1'b1;  // MAC is held cleared for the whole reset
      rv_q     <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      clr_q <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        // A pair accepted on this edge is dropped; the MAC is wiped instead.
        state_q <= ST_IDLE;
        rv_q    <= 1'b0;
        clr_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              rem_q   <= len;
              clr_q   <= 1'b1;
              state_q <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            settle_q <= '0;
            state_q  <= (rem_q == '0) ? ST_SETTLE : ST_STREAM;
          end
          ST_STREAM: begin
            if (op_hs) begin
              in1_q <= op_a;
              in2_q <= op_b;
              en_q  <= 1'b1;
              rem_q <= rem_q - LEN_W'(1);
              if (rem_q == LEN_W'(1)) begin
                settle_q <= '0;
                state_q  <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
              result_q <= mac_acc;
              rv_q     <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              settle_q <= settle_q + 2'd1;
            end
          end
          ST_DONE: begin
            if (result_ready) begin
              rv_q    <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bf_mac_feeder.sv
// Directed bench for bf_mac_feeder with an inline accumulate-only MAC stub.
module tb_bf_mac_feeder;
  import bf_mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] mac_in_1;
  logic [15:0] mac_in_2;
  logic        mac_en;
  logic        mac_clr;
  logic [15:0] mac_acc = '0;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  logic [15:0] exp_q[$];

  bf_mac_feeder #(.LEN_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .busy(busy),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .mac_in_1(mac_in_1), .mac_in_2(mac_in_2), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_acc(mac_acc), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // MAC stub: clear wins over accumulate, one-cycle update
  always @(posedge clk) begin : bf_mac_stub
    if (mac_clr) mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + mac_in_1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_en) en_cnt++;
      if (mac_clr) clr_cnt++;
      if (result_valid && result_ready) begin
        chk("res_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("result", {16'h0, result}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    logic ok;
    ok = 1'b0;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (op_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    op_valid = 1'b0;
    chk("op_hs", {31'h0, ok}, 32'd1);
  endtask

  task automatic wait_result();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("rv_timeout", {31'h0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("idle_timeout", {31'h0, ok}, 32'd1);
  endtask

  initial begin
    int en0;
    int clr0;
    int n;

    // Reset
    tick(); tick(); tick();
    chk("rst_clr", {31'h0, mac_clr}, 32'd1);
    chk("rst_en", {31'h0, mac_en}, 32'd0);
    chk("rst_in1", {16'h0, mac_in_1}, 32'h0);
    chk("rst_in2", {16'h0, mac_in_2}, 32'h0);
    chk("rst_res", {16'h0, result}, 32'h0);
    chk("rst_rv", {31'h0, result_valid}, 32'd0);
    chk("rst_rdy", {31'h0, op_ready}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_state", {29'h0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_clr", {31'h0, mac_clr}, 32'd0);
    chk("rel_busy", {31'h0, busy}, 32'd0);

    // len=1, pair presented together with start
    en0 = en_cnt;
    exp_q.push_back(BF16_ONE);
    op_a = BF16_ONE;
    op_b = BF16_TWO;
    op_valid = 1'b1;
    start_job(8'd1);
    chk("t1_clear_clr", {31'h0, mac_clr}, 32'd1);
    chk("t1_clear_busy", {31'h0, busy}, 32'd1);
    chk("t1_clear_rdy", {31'h0, op_ready}, 32'd0);
    tick();
    chk("t1_stream_rdy", {31'h0, op_ready}, 32'd1);
    tick();
    op_valid = 1'b0;
    chk("t1_en", {31'h0, mac_en}, 32'd1);
    chk("t1_in1", {16'h0, mac_in_1}, {16'h0, BF16_ONE});
    chk("t1_in2", {16'h0, mac_in_2}, {16'h0, BF16_TWO});
    chk("t1_rdy_off", {31'h0, op_ready}, 32'd0);
    tick();
    chk("t1_en_off", {31'h0, mac_en}, 32'd0);
    chk("t1_rv_t2", {31'h0, result_valid}, 32'd0);
    tick();
    chk("t1_rv_t3", {31'h0, result_valid}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_rv_hold", {31'h0, result_valid}, 32'd1);
      chk("t1_res_hold", {16'h0, result}, {16'h0, BF16_ONE});
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("t1_rv_drop", {31'h0, result_valid}, 32'd0);
    chk("t1_idle", {31'h0, busy}, 32'd0);
    chk("t1_en_cnt", 32'(en_cnt - en0), 32'd1);

    // len=3 with a gap between pairs 2 and 3
    en0 = en_cnt;
    exp_q.push_back(16'h0006);
    start_job(8'd3);
    send_pair(16'h0001, BF16_ONE);
    send_pair(16'h0002, BF16_ONE);
    tick(); tick();
    chk("t2_gap_en", {31'h0, mac_en}, 32'd0);
    chk("t2_gap_hold", {16'h0, mac_in_1}, 32'h2);
    send_pair(16'h0003, BF16_ONE);
    chk("t2_rdy_off", {31'h0, op_ready}, 32'd0);
    wait_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("t2_en_cnt", 32'(en_cnt - en0), 32'd3);

    // len=0: CLEAR then SETTLE only
    en0 = en_cnt;
    exp_q.push_back(16'h0000);
    start_job(8'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (result_valid) break;
      if (busy) n++;
      tick();
    end
    chk("t3_latency", 32'(n), 32'd3);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("t3_en_cnt", 32'(en_cnt - en0), 32'd0);

    // abort after one of four pairs, coincident with a second handshake
    en0 = en_cnt;
    start_job(8'd4);
    send_pair(16'h0009, BF16_ONE);
    op_a = 16'h0100;
    op_valid = 1'b1;
    abort = 1'b1;
    chk("t4_rdy", {31'h0, op_ready}, 32'd1);
    tick();
    abort = 1'b0;
    op_valid = 1'b0;
    chk("t4_busy", {31'h0, busy}, 32'd0);
    chk("t4_en", {31'h0, mac_en}, 32'd0);
    chk("t4_clr", {31'h0, mac_clr}, 32'd1);
    chk("t4_rv", {31'h0, result_valid}, 32'd0);
    tick();
    chk("t4_clr_off", {31'h0, mac_clr}, 32'd0);
    chk("t4_rv_still", {31'h0, result_valid}, 32'd0);
    chk("t4_en_cnt", 32'(en_cnt - en0), 32'd1);
    exp_q.push_back(16'h000A);
    start_job(8'd2);
    send_pair(16'h0005, BF16_ONE);
    send_pair(16'h0005, BF16_ONE);
    wait_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // back-to-back jobs, result_ready tied high, start while busy ignored
    en0 = en_cnt;
    clr0 = clr_cnt;
    result_ready = 1'b1;
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h000E);
    start_job(8'd2);
    send_pair(16'h0001, BF16_ONE);
    send_pair(16'h0001, BF16_ONE);
    start_job(8'd5);
    wait_idle();
    start_job(8'd2);
    chk("t5_clr2", {31'h0, mac_clr}, 32'd1);
    send_pair(16'h0007, BF16_ONE);
    send_pair(16'h0007, BF16_ONE);
    wait_idle();
    tick();
    chk("t5_stay_idle", {31'h0, busy}, 32'd0);
    chk("t5_en_cnt", 32'(en_cnt - en0), 32'd4);
    chk("t5_clr_cnt", 32'(clr_cnt - clr0), 32'd2);
    result_ready = 1'b0;
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
